// File: rtl/mac_seq_ctrl_pkg.sv
// Shared definitions for the MAC sequencer: FSM state encoding and the
// datapath widths used by the controller and its accumulator.
package mac_seq_ctrl_pkg;

   localparam int DATA_W = 8;   // operand width
   localparam int LEN_W  = 5;   // element-count width
   localparam int ACC_W  = 13;  // accumulator / result width

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/mac2.sv
// mac2 -- accumulator of the upper byte of an unsigned 8x8 product.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high clear of the accumulator
//   en   add the current product's upper byte this cycle
//   a, b unsigned operands
//   acc  running sum
module mac2
   import mac_seq_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc
);

   // Truncate the full product to its upper byte (floor of a*b/256).
   function automatic logic [DATA_W-1:0] prod_hi(input logic [DATA_W-1:0] x,
                                                 input logic [DATA_W-1:0] y);
      logic [2*DATA_W-1:0] p;
      p = {{DATA_W{1'b0}}, x} * {{DATA_W{1'b0}}, y};
      return p[2*DATA_W-1:DATA_W];
   endfunction

   logic [ACC_W-1:0] acc_p0;

   // Stage 0: accumulate; 31 * 254 fits in ACC_W bits, so no wrap is possible.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0 <= '0;
      end else if (en) begin
         acc_p0 <= acc_p0 + {{(ACC_W-DATA_W){1'b0}}, prod_hi(a, b)};
      end
   end

   assign acc = acc_p0;

endmodule

// File: rtl/mac_seq_ctrl.sv
// mac_seq_ctrl -- sequences a dot-product-style run over len elements of two
// operand memories that share one read address, accumulating the upper byte
// of each product in mac2 and reporting the sum with a one-cycle done pulse.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, len        run request (sampled in IDLE) and element count
//   rd_en, addr       operand-memory read strobe and address
//   rdata_a, rdata_b  read data, valid the cycle after rd_en
//   busy              high whenever not IDLE
//   done              one-cycle completion pulse
//   result            final sum, held until the next done
module mac_seq_ctrl
   import mac_seq_ctrl_pkg::*;
#(
   parameter int ADDR_W = 5
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] rdata_a,
   input  logic [DATA_W-1:0] rdata_b,
   output logic              busy,
   output logic              done,
   output logic [ACC_W-1:0]  result
);

   state_t             state, state_nxt;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   idx;
   logic [LEN_W:0]     idx_inc;
   logic               last;
   logic               mac_clr;
   logic               mac_en;
   logic [ACC_W-1:0]   acc;
   logic [ACC_W-1:0]   result_q;

   assign idx_inc = {1'b0, idx} + (LEN_W+1)'(1);
   assign last    = (idx_inc == {1'b0, len_q});

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         len_q    <= '0;
         idx      <= '0;
         result_q <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE && start) begin
            len_q <= len;
         end
         if (state == CLEAR) begin
            idx <= '0;
         end else if (state == RUN) begin
            idx <= idx_inc[LEN_W-1:0];
         end
         if (state == DONE) begin
            result_q <= result;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      rd_en     = 1'b0;
      addr      = '0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      busy      = 1'b1;
      done      = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_nxt = (len == '0) ? DONE : CLEAR;
            end
         end
         CLEAR: begin
            // Issue address 0 while the accumulator clears, so its data
            // lands exactly in the first RUN cycle.
            mac_clr   = 1'b1;
            rd_en     = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            // Accumulate element idx while prefetching idx+1.
            mac_en = 1'b1;
            if (!last) begin
               rd_en              = 1'b1;
               addr[LEN_W-1:0]    = idx_inc[LEN_W-1:0];
            end else begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Present the sum during the done cycle itself; a zero-length run never
   // cleared the accumulator, so it reports 0 explicitly.
   assign result = (state == DONE) ? ((len_q == '0) ? '0 : acc) : result_q;

   mac2 u_mac2 (
      .clk (clk),
      .rst (rst | mac_clr),
      .en  (mac_en),
      .a   (rdata_a),
      .b   (rdata_b),
      .acc (acc)
   );

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 5, width of the operand-memory address; SHALL be >= 5.
REQ-002 Single clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  run request; sampled only in IDLE.
REQ-006 len  in  5  element count, 0..31; latched when start is accepted.
REQ-007 rd_en  out  1  operand-memory read strobe.
REQ-008 addr  out  ADDR_W  shared read address for the A and B memories.
REQ-009 rdata_a, rdata_b  in  8 each  memory read data, valid one cycle after the rd_en/addr cycle.
REQ-010 busy  out  1  high in every state except IDLE.
REQ-011 done  out  1  one-cycle completion pulse.
REQ-012 result  out  13  final accumulated sum; held until the next done.

Function
REQ-013 FSM states SHALL be IDLE, CLEAR, RUN and DONE.
REQ-014 Transitions:
- IDLE->CLEAR on start with len!=0.
- IDLE->DONE on start with len==0.
- CLEAR->RUN.
- RUN->DONE after exactly len RUN cycles.
- DONE->IDLE.
REQ-015 CLEAR actions: assert the MAC clear, rd_en=1, addr=0.
REQ-016 RUN cycle k (k=0..len-1) actions:
- Assert mac_en so that rdata_a/rdata_b from address k are accumulated.
- If k+1<len, assert rd_en with addr=k+1; otherwise rd_en=0.
REQ-017 Addresses SHALL be issued strictly in order 0..len-1, each exactly once, with no bubbles.
REQ-018 Accumulation rule: each step adds product[15:8] of the unsigned 8x8 product to a 13-bit accumulator; the worst case (31*254=7874) cannot overflow, so no saturation logic.
REQ-019 In DONE: result loads the accumulator value (0 when len==0) and done=1 for exactly that cycle.
REQ-020 Latency: with start accepted in cycle 0, done SHALL assert in cycle len+2 for len>=1, and in cycle 1 for len==0.
REQ-021 start while busy SHALL be ignored; len is not re-latched.
REQ-022 A new start SHALL be accepted in the first IDLE cycle after DONE; the minimum start-to-start spacing is len+3 cycles.
REQ-023 Outside CLEAR/RUN: rd_en=0, addr=0 and mac_en=0.
REQ-024 A changing len input during a run SHALL have no effect.

Reset
REQ-025 On rst: state=IDLE, busy=0, done=0, result=0, rd_en=0, addr=0, and the accumulator is cleared.
REQ-026 rst asserted mid-run SHALL abort the run in the same edge: no done pulse, and result returns to 0.
REQ-027 rst SHALL take priority over start in the same cycle.

Structure
REQ-028 A shared package SHALL hold:
- the state enum typedef;
- the constants DATA_W=8, LEN_W=5, ACC_W=13.
REQ-029 One sub-module SHALL be instantiated: the existing mac2 accumulator.
- Its rst pin is driven by (rst | clear).
- Its en pin is driven by the RUN-state enable.
- Its 13-bit output feeds the result register.
REQ-030 All control logic (FSM, index counter, result register) SHALL reside in mac_seq_ctrl.

Verification
REQ-031 len=4, all A=B=0x80 (product 0x4000, upper byte 64) -> done in cycle 6, result=256.
REQ-032 len=31, all A=B=0xFF (upper byte 254) -> done in cycle 33, result=7874; addr sequence 0..30 with no gaps.
REQ-033 len=0 -> done in cycle 1, result=0, rd_en never asserted.
REQ-034 start pulsed in cycle 3 of a len=8 run -> ignored; a single done in cycle 10.
REQ-035 rst in cycle 3 of a len=8 run -> IDLE next cycle, result=0, no done; a following len=2 run with A=B=0x80 -> result=128.
REQ-036 Back-to-back runs (len=3 with A=B=0x80, then len=1 with A=0xFF, B=0x02 (upper byte 1)) -> results 192 then 1, with no carry-over between runs.
